rca_8bit: RTL and testbench

RCA_8BIT -- requirements
Module: rca_8bit

---
 rtl/rca_8bit.sv | 45 ++++
 tb/tb_rca_8bit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/rca_8bit.sv
// rtl/rca_8bit.sv - registered ripple-carry adder with carry-out and signed overflow
module rca_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = ci;

    // One full-adder cell per bit; the carry ripples from cell i into cell i+1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Result registers only load on qualified input, so idle inputs never reach them.
            if (in_valid) begin
                s   <= sum;
                co  <= c[WIDTH];
                ovf <= c[WIDTH-1] ^ c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_rca_8bit.sv
// tb/tb_rca_8bit.sv - scoreboard bench for rca_8bit
module tb_rca_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] x;
    logic [7:0] y;
    logic       ci;
    logic       in_valid;
    logic [7:0] s;
    logic       co;
    logic       ovf;
    logic       out_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Expected word: {out_valid, ovf, co, s}
    logic [10:0] exp_q[$];
    logic [10:0] hold;

    rca_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x         (x),
        .y         (y),
        .ci        (ci),
        .in_valid  (in_valid),
        .s         (s),
        .co        (co),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [10:0] ref_result(input logic [7:0] a, input logic [7:0] b, input logic c);
        int          sr;
        logic [8:0]  u;
        logic        v;
        u  = {1'b0, a} + {1'b0, b} + {8'd0, c};
        sr = int'($signed(a)) + int'($signed(b)) + int'(c);
        v  = (sr > 127) || (sr < -128);
        return {1'b1, v, u};
    endfunction

    task automatic drive(input string tag, input logic r, input logic v,
                         input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [10:0] want;
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        x        = a;
        y        = b;
        ci       = c;
        if (!r) begin
            exp_q.delete();
            hold = '0;
        end else if (v) begin
            exp_q.push_back(ref_result(a, b, c));
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            hold = {1'b0, want[9:0]};
        end else begin
            want = hold;
        end
        check(tag, {21'd0, out_valid, ovf, co, s}, {21'd0, want});
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        ci       = 1'b0;
        hold     = '0;

        drive("reset0", 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive("reset1", 1'b0, 1'b1, 8'h12, 8'h34, 1'b1);
        drive("zero",   1'b1, 1'b1, 8'h00, 8'h00, 1'b0);

        drive("seq0", 1'b1, 1'b1, 8'h01, 8'h02, 1'b1);
        drive("seq1", 1'b1, 1'b1, 8'h03, 8'h04, 1'b1);
        drive("seq2", 1'b1, 1'b1, 8'h04, 8'h05, 1'b0);
        drive("seq3", 1'b1, 1'b1, 8'h06, 8'h0C, 1'b1);

        // Hold 0x13 across idle cycles with changing and unknown operands
        drive("hold0", 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
        drive("hold1", 1'b1, 1'b0, 8'h5A, 8'hC3, 1'b0);
        drive("hold2", 1'b1, 1'b0, 8'bx,  8'bx,  1'bx);

        drive("wrap_ff_01", 1'b1, 1'b1, 8'hFF, 8'h01, 1'b0);
        drive("ovf_7f_01",  1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
        drive("ovf_80_80",  1'b1, 1'b1, 8'h80, 8'h80, 1'b0);
        drive("wrap_ff_00", 1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
        drive("wrap_ff_ff", 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
        drive("max_neg",    1'b1, 1'b1, 8'h80, 8'hFF, 1'b0);

        drive("rst_prio",  1'b0, 1'b1, 8'hAA, 8'h55, 1'b1);
        drive("after_rst", 1'b1, 1'b1, 8'hAA, 8'h55, 1'b1);

        drive("mid0",     1'b1, 1'b1, 8'h10, 8'h20, 1'b0);
        drive("mid_rst",  1'b0, 1'b0, 8'h30, 8'h40, 1'b0);
        drive("mid_idle", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        drive("mid_post", 1'b1, 1'b1, 8'h11, 8'h22, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            drive("rand", 1'b1, ($urandom_range(0, 3) != 0),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
